uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO write port between
// two byte-stream sources, with an optional per-packet source tag byte.
module uart_tx_arbiter #(
    parameter logic [7:0]  SRC0_TAG = 8'hA0,
    parameter logic [7:0]  SRC1_TAG = 8'hA1,
    parameter bit          TAG_EN   = 1'b1,
    parameter int unsigned MAX_PKT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_last,
    output logic       s1_ready,
    input  logic       uart_tx_full,
    input  logic       uart_tx_almost_full,
    output logic [7:0] uart_wr_data,
    output logic       uart_wr_en,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t           state, state_nxt;
    logic [1:0]       grant_nxt;
    logic             last_src1, last_src1_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       wr_data_nxt;
    logic             wr_en_nxt;
    logic             can_wr;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;
    logic             accept;
    logic             pick0;

    // One free slot is kept in reserve for the write already in flight.
    assign can_wr    = !uart_tx_almost_full && !uart_tx_full;
    assign s0_ready  = (state == DATA) && grant[0] && can_wr;
    assign s1_ready  = (state == DATA) && grant[1] && can_wr;
    assign sel_valid = grant[0] ? s0_valid : s1_valid;
    assign sel_last  = grant[0] ? s0_last  : s1_last;
    assign sel_data  = grant[0] ? s0_data  : s1_data;
    assign accept    = (state == DATA) && (|grant) && sel_valid && can_wr;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= 2'b00;
            last_src1    <= 1'b1;
            cnt          <= '0;
            uart_wr_data <= 8'h00;
            uart_wr_en   <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            last_src1    <= last_src1_nxt;
            cnt          <= cnt_nxt;
            uart_wr_data <= wr_data_nxt;
            uart_wr_en   <= wr_en_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_src1_nxt = last_src1;
        cnt_nxt       = cnt;
        wr_data_nxt   = uart_wr_data;
        wr_en_nxt     = 1'b0;
        pick0         = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (s0_valid || s1_valid) begin
                    // Ties go to whichever source was not granted last.
                    pick0     = s0_valid && (!s1_valid || last_src1);
                    grant_nxt = pick0 ? 2'b01 : 2'b10;
                    state_nxt = TAG_EN ? HDR : DATA;
                end
            end
            HDR: begin
                if (can_wr) begin
                    wr_data_nxt = grant[1] ? SRC1_TAG : SRC0_TAG;
                    wr_en_nxt   = 1'b1;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    wr_data_nxt = sel_data;
                    wr_en_nxt   = 1'b1;
                    cnt_nxt     = cnt + CNT_W'(1);
                    // Release on end-of-packet or on a forced split at the length cap.
                    if (sel_last || (cnt_nxt == CNT_W'(MAX_PKT))) begin
                        state_nxt     = IDLE;
                        grant_nxt     = 2'b00;
                        last_src1_nxt = grant[1];
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

endmodule
